// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - elastic MEM->WB queue of DEPTH records with valid/ready on both sides
// Optional writeback forwarding search is enabled by defining WB_QUEUE_FWD_EN.
module wb_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       mem_pc,
  input  logic [DATA_W-1:0]       mem_vd,
  input  logic [REG_AW-1:0]       mem_rd,
  input  logic                    mem_rd_enable,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [ADDR_W-1:0]       wb_pc,
  output logic [DATA_W-1:0]       wb_vd,
  output logic [REG_AW-1:0]       wb_rd,
  output logic                    wb_rd_enable,
`ifdef WB_QUEUE_FWD_EN
  input  logic [REG_AW-1:0]       fwd_raddr,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc [DEPTH];
  logic [DATA_W-1:0] r_vd [DEPTH];
  logic [REG_AW-1:0] r_rd [DEPTH];
  logic              r_en [DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  // in_ready is held low while reset is asserted even if rdy is high
  assign in_ready = rst & rdy & ~w_full;
  assign wb_valid = (r_count != '0);
  assign w_push   = in_valid & in_ready;
  assign w_pop    = wb_valid & wb_ready & rdy;
  assign count    = r_count;

  assign wb_pc        = wb_valid ? r_pc[r_rp] : '0;
  assign wb_vd        = wb_valid ? r_vd[r_rp] : '0;
  assign wb_rd        = wb_valid ? r_rd[r_rp] : '0;
  assign wb_rd_enable = wb_valid & r_en[r_rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i] <= '0;
        r_vd[i] <= '0;
        r_rd[i] <= '0;
        r_en[i] <= 1'b0;
      end
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc[r_wp] <= mem_pc;
        r_vd[r_wp] <= mem_vd;
        r_rd[r_wp] <= mem_rd;
        r_en[r_wp] <= mem_rd_enable & (mem_rd != '0);
        r_wp       <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_QUEUE_FWD_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest so the last match wins (youngest entry nearest wp)
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = r_rp;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rp + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && r_en[w_idx] && (r_rd[w_idx] == fwd_raddr) &&
          (fwd_raddr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_vd[w_idx];
      end
    end
  end
`endif

endmodule
